// File: rtl/unit_output_buf_if.sv
// Write/close port from the CPU and FIFO-style halfword read port toward
// the unit's output arbiter.
interface unit_output_buf_if #(
  parameter int UOB_ADDR_MSB = 3,
  parameter int OUT_WIDTH    = 16
);
  logic [2*OUT_WIDTH-1:0] din;
  logic                   wr_en;
  logic [UOB_ADDR_MSB:0]  wr_addr;
  logic                   set_input_complete;
  logic                   ready;
  logic                   full;
  logic [OUT_WIDTH-1:0]   dout;
  logic                   empty;
  logic                   rd_en;

  modport master (
    output din, wr_en, wr_addr, set_input_complete, rd_en,
    input  ready, full, dout, empty
  );

  modport slave (
    input  din, wr_en, wr_addr, set_input_complete, rd_en,
    output ready, full, dout, empty
  );
endinterface

// File: rtl/unit_output_buf.sv
// Packet buffer behind the sha512unit CPU: collects 32-bit result words, then
// drains words 0..max_addr as low/high 16-bit halfwords once the packet closes.
module unit_output_buf #(
  parameter int UOB_ADDR_MSB = 3,
  parameter int OUT_WIDTH    = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  unit_output_buf_if.slave         bus
);
  localparam int AW      = UOB_ADDR_MSB + 1;
  localparam int N_WORDS = 2 ** AW;
  localparam int WORD_W  = 2 * OUT_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_READ0, S_LOAD, S_OUT} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     max_addr_q, max_addr_d;
  logic [AW-1:0]     word_idx_q, word_idx_d;
  logic              sel_hi_q, sel_hi_d;
  logic [WORD_W-1:0] out_word_q, out_word_d;
  logic              ready_q, ready_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              ram_we;
  logic [WORD_W-1:0] rdata_q;
  logic [WORD_W-1:0] ram_q [N_WORDS];

  always_comb begin
    state_d    = state_q;
    max_addr_d = max_addr_q;
    word_idx_d = word_idx_q;
    sel_hi_d   = sel_hi_q;
    out_word_d = out_word_q;
    ram_we     = 1'b0;
    case (state_q)
      S_IDLE: begin
        word_idx_d = '0;
        // A close without any write is a zero-length packet: nothing to drain.
        if (bus.wr_en) begin
          ram_we     = 1'b1;
          max_addr_d = bus.wr_addr;
          state_d    = bus.set_input_complete ? S_READ0 : S_FILL;
        end
      end
      S_FILL: begin
        if (bus.wr_en) begin
          ram_we = 1'b1;
          if (bus.wr_addr > max_addr_q) max_addr_d = bus.wr_addr;
        end
        if (bus.set_input_complete) state_d = S_READ0;
      end
      S_READ0: begin
        word_idx_d = '0;
        state_d    = S_LOAD;
      end
      S_LOAD: begin
        out_word_d = rdata_q;
        sel_hi_d   = 1'b0;
        state_d    = S_OUT;
      end
      S_OUT: begin
        if (bus.rd_en) begin
          if (!sel_hi_q) begin
            sel_hi_d = 1'b1;
          end else if (word_idx_q < max_addr_q) begin
            word_idx_d = word_idx_q + AW'(1);
            state_d    = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Flags are registered copies of the next state so they line up with it.
  assign ready_d = (state_d == S_IDLE);
  assign full_d  = (state_d == S_READ0) || (state_d == S_LOAD) || (state_d == S_OUT);
  assign empty_d = (state_d != S_OUT);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      max_addr_q <= '0;
      word_idx_q <= '0;
      sel_hi_q   <= 1'b0;
      out_word_q <= '0;
      ready_q    <= 1'b1;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      max_addr_q <= max_addr_d;
      word_idx_q <= word_idx_d;
      sel_hi_q   <= sel_hi_d;
      out_word_q <= out_word_d;
      ready_q    <= ready_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
    end
  end

  // Read address follows the next word index, giving the one-cycle BRAM latency.
  always_ff @(posedge CLK) begin
    if (ram_we && !RST) ram_q[bus.wr_addr] <= bus.din;
    rdata_q <= ram_q[word_idx_d];
  end

  assign bus.ready = ready_q;
  assign bus.full  = full_q;
  assign bus.empty = empty_q;
  assign bus.dout  = sel_hi_q ? out_word_q[WORD_W-1:OUT_WIDTH] : out_word_q[OUT_WIDTH-1:0];
endmodule

// File: tb/tb_unit_output_buf.sv
// Randomized bench for unit_output_buf: a packet-level model fills a halfword
// queue on every close, and a monitor pops and compares on every consumed halfword.
module tb_unit_output_buf;
  localparam int AMSB = 3;
  localparam int AW   = AMSB + 1;
  localparam int NW   = 2 ** AW;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  unit_output_buf_if #(.UOB_ADDR_MSB(AMSB), .OUT_WIDTH(16)) bus ();
  unit_output_buf #(.UOB_ADDR_MSB(AMSB), .OUT_WIDTH(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  int          pops   = 0;
  int          rd_mode = 0;   // 0 idle, 1 always pop, 2 random pop
  logic [15:0] exp_q [$];
  logic [31:0] mem_m [NW];
  bit          busy = 1'b0;   // packet closed, model refuses writes
  bit          open = 1'b0;   // at least one word written since last close
  int          max_m = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Consumer side
  initial begin
    bus.rd_en = 1'b0;
    forever begin
      @(posedge CLK); #1;
      case (rd_mode)
        1:       bus.rd_en = 1'b1;
        2:       bus.rd_en = 1'($urandom_range(0, 1));
        default: bus.rd_en = 1'b0;
      endcase
    end
  end

  // Monitor: a halfword is consumed whenever empty=0 and rd_en=1 at the edge
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge CLK);
      if (!RST && bus.empty === 1'b0 && bus.rd_en === 1'b1) begin
        pops++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %0h expected no output", bus.dout);
        end else begin
          e = exp_q.pop_front();
          chk("dout", 32'(bus.dout), 32'(e));
        end
      end
      if (bus.ready === 1'b1) chk("ready_implies_not_full", 32'(bus.full), 32'd0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge CLK); #2;
  endtask

  task automatic model_wr(input int a, input logic [31:0] d);
    if (!busy) begin
      mem_m[a] = d;
      if (!open || a > max_m) max_m = a;
      open = 1'b1;
    end
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(a);
    bus.din     = d;
    model_wr(a, d);
    cyc();
    bus.wr_en = 1'b0;
  endtask

  task automatic close_pkt(input bit with_wr, input int a, input logic [31:0] d);
    bit was_open;
    bus.set_input_complete = 1'b1;
    if (with_wr) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = AW'(a);
      bus.din     = d;
      model_wr(a, d);
    end
    was_open = open;
    if (open) begin
      for (int i = 0; i <= max_m; i++) begin
        exp_q.push_back(mem_m[i][15:0]);
        exp_q.push_back(mem_m[i][31:16]);
      end
      busy = 1'b1;
      open = 1'b0;
    end
    cyc();
    bus.set_input_complete = 1'b0;
    bus.wr_en = 1'b0;
    if (was_open) begin
      chk("full_at_t1", 32'(bus.full), 32'd1);
      chk("ready_at_t1", 32'(bus.ready), 32'd0);
      cyc();
      chk("empty_at_t2", 32'(bus.empty), 32'd1);
      cyc();
      chk("empty_at_t3", 32'(bus.empty), 32'd0);
    end else begin
      chk("zero_len_ready", 32'(bus.ready), 32'd1);
      chk("zero_len_full", 32'(bus.full), 32'd0);
      cyc();
      chk("zero_len_empty", 32'(bus.empty), 32'd1);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (!(bus.ready === 1'b1 && exp_q.size() == 0) && n < 3000) begin
      cyc();
      n++;
    end
    chk("drain_done", 32'(n < 3000), 32'd1);
    chk("idle_ready", 32'(bus.ready), 32'd1);
    chk("idle_full", 32'(bus.full), 32'd0);
    chk("idle_empty", 32'(bus.empty), 32'd1);
    busy = 1'b0;
  endtask

  initial begin
    int len, j, tmp, p0, n;
    int addrs [$];
    bus.din = '0;
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.set_input_complete = 1'b0;

    RST = 1'b1;
    repeat (2) cyc();
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_dout", 32'(bus.dout), 32'd0);
    RST = 1'b0;

    // Two-word packet, consumer always ready
    rd_mode = 1;
    wr(0, 32'h1111_2222);
    wr(1, 32'h3333_4444);
    close_pkt(1'b0, 0, 32'h0);
    drain();

    // Write on the closing cycle belongs to the packet
    rd_mode = 2;
    wr(0, $urandom);
    wr(1, $urandom);
    close_pkt(1'b1, 2, 32'hAAAA_BBBB);
    drain();

    // Backpressure, plus write and close attempts while full
    wr(0, $urandom);
    wr(1, $urandom);
    wr(2, $urandom);
    wr(3, $urandom);
    close_pkt(1'b0, 0, 32'h0);
    chk("full_before_ignored_wr", 32'(bus.full), 32'd1);
    wr(0, 32'hDEAD_BEEF);
    bus.set_input_complete = 1'b1;
    cyc();
    bus.set_input_complete = 1'b0;
    drain();
    // Only word 1 rewritten: word 0 must still hold its pre-DEADBEEF contents
    wr(1, $urandom);
    close_pkt(1'b0, 0, 32'h0);
    drain();

    // Zero-length packet
    close_pkt(1'b0, 0, 32'h0);
    cyc();
    chk("zero_len_still_ready", 32'(bus.ready), 32'd1);
    chk("zero_len_still_empty", 32'(bus.empty), 32'd1);

    // Full depth
    for (int a = 0; a < NW; a++) wr(a, $urandom);
    close_pkt(1'b0, 0, 32'h0);
    drain();

    // Random packets: shuffled contiguous addresses with occasional rewrites
    repeat (8) begin
      rd_mode = int'($urandom_range(1, 2));
      len = int'($urandom_range(1, NW));
      addrs.delete();
      for (int i = 0; i < len; i++) addrs.push_back(i);
      for (int i = 0; i < len; i++) begin
        j = int'($urandom_range(0, len - 1));
        tmp = addrs[i]; addrs[i] = addrs[j]; addrs[j] = tmp;
      end
      for (int i = 0; i < len - 1; i++) begin
        wr(addrs[i], $urandom);
        if ($urandom_range(0, 3) == 0) wr(addrs[i], $urandom);
      end
      if ($urandom_range(0, 1) == 1) begin
        close_pkt(1'b1, addrs[len-1], $urandom);
      end else begin
        wr(addrs[len-1], $urandom);
        close_pkt(1'b0, 0, 32'h0);
      end
      drain();
    end

    // Reset after three halfwords have been consumed
    rd_mode = 1;
    for (int a = 0; a < 4; a++) wr(a, $urandom);
    p0 = pops;
    close_pkt(1'b0, 0, 32'h0);
    n = 0;
    while (pops - p0 < 3 && n < 100) begin
      cyc();
      n++;
    end
    rd_mode = 0;
    bus.rd_en = 1'b0;
    chk("three_popped", 32'(pops - p0), 32'd3);
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    chk("midrst_empty", 32'(bus.empty), 32'd1);
    chk("midrst_ready", 32'(bus.ready), 32'd1);
    chk("midrst_full", 32'(bus.full), 32'd0);
    chk("midrst_dout", 32'(bus.dout), 32'd0);
    exp_q.delete();
    busy = 1'b0;
    open = 1'b0;
    rd_mode = 1;
    p0 = pops;
    wr(0, $urandom);
    close_pkt(1'b0, 0, 32'h0);
    drain();
    chk("one_word_halfwords", 32'(pops - p0), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
